// File: rtl/montgomery_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier core between two requesters.
// One operation is in flight at a time; the winner gets its result with a 1-cycle ack.
module montgomery_arbiter #(
  parameter int WIDTH = 381,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_m,
  output logic             mm_out_read,
  input  logic [WIDTH-1:0] mm_result,
  input  logic             mm_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic             gnt_q;
  logic             rr_ptr_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             mm_start_q;
  logic [WIDTH-1:0] mm_a_q;
  logic [WIDTH-1:0] mm_b_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] op_count_q;
  logic             win_d;

  // On contention the pointer decides; otherwise the lone requester wins.
  always_comb begin
    win_d = req1;
    if (req0 && req1) win_d = rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      rr_ptr_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      result_q   <= '0;
      op_count_q <= '0;
    end else begin
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      mm_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            mm_a_q     <= win_d ? a1 : a0;
            mm_b_q     <= win_d ? b1 : b0;
            gnt_q      <= win_d;
            rr_ptr_q   <= ~win_d;
            mm_start_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (mm_done) begin
            result_q <= mm_result;
            ack0_q   <= ~gnt_q;
            ack1_q   <= gnt_q;
            state_q  <= RESP;
          end
        end
        RESP: begin
          op_count_q <= op_count_q + CNT_ONE;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result handshake back to the core is same-cycle with its done.
  assign mm_out_read = (state_q == WAIT) && mm_done;
  assign mm_m        = in_m;
  assign busy        = (state_q != IDLE);
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign mm_start    = mm_start_q;
  assign mm_a        = mm_a_q;
  assign mm_b        = mm_b_q;
  assign result      = result_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_montgomery_arbiter.sv
// Bench for montgomery_arbiter: a toy core (done 10 cycles after start, result a^b)
// plus scenario tasks that compare the DUT against expectations derived from the rules.
module tb_montgomery_arbiter;
  localparam int W  = 61;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0, in_m = '0;
  logic          ack0, ack1, busy, mm_start, mm_out_read, mm_done;
  logic [W-1:0]  result, mm_a, mm_b, mm_m, mm_result;
  logic [CW-1:0] op_count;

  logic          core_done = 1'b0, spur = 1'b0;
  logic [W-1:0]  core_res = '0, junk = '0;
  int            ccnt = 0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  assign mm_done   = core_done | spur;
  assign mm_result = spur ? junk : core_res;

  montgomery_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
    .in_m(in_m), .result(result), .busy(busy), .op_count(op_count),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_out_read(mm_out_read), .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Toy core: done pulses 10 cycles after start, product is a^b; shares resetn.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (!resetn) ccnt = 0;
      else begin
        if (ccnt > 0) begin
          ccnt--;
          if (ccnt == 0) begin
            core_done = 1'b1;
            core_res  = mm_a ^ mm_b;
          end
        end
        if (mm_start) ccnt = 10;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; spur = 1'b0;
    in_m = rnd();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Advances to the next ack (bounded); who = -1 on timeout, 2 if both acks fire.
  task automatic wait_ack(input int maxc, output int who, output int at);
    bit found;
    found = 1'b0;
    who = -1; at = -1;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        who = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        at = cyc;
        found = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ack0, ack1, mm_start, busy, mm_out_read} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {ack0, ack1, mm_start, busy, mm_out_read});
    end
    checks++;
    if (mm_a !== '0 || mm_b !== '0) begin
      errors++; $display("FAIL reset_operands got %h/%h want 0/0", mm_a, mm_b);
    end
    checks++;
    if (result !== '0 || op_count !== '0) begin
      errors++; $display("FAIL reset_result got %h cnt %0d want 0 cnt 0", result, op_count);
    end
    checks++;
    if (mm_m !== in_m) begin
      errors++; $display("FAIL mm_m_pass got %h want %h", mm_m, in_m);
    end
  endtask

  task automatic test_single();
    int t, st, at, reads, acks0, acks1;
    do_reset();
    @(negedge clk);
    a0 = 5; b0 = 3; req0 = 1'b1; t = cyc;
    st = -1; at = -1; reads = 0; acks0 = 0; acks1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mm_start && st < 0) begin
        st = cyc;
        checks++;
        if (mm_a !== W'(5) || mm_b !== W'(3) || busy !== 1'b1) begin
          errors++; $display("FAIL single_issue got a=%0d b=%0d busy=%b want 5 3 1", mm_a, mm_b, busy);
        end
      end
      if (mm_out_read) reads++;
      if (ack1) acks1++;
      if (ack0) begin
        acks0++;
        if (at < 0) begin
          at = cyc;
          req0 = 1'b0;
          checks++;
          if (result !== W'(6)) begin
            errors++; $display("FAIL single_result got %0d want 6", result);
          end
        end
      end
    end
    checks++;
    if (st != t + 1) begin
      errors++; $display("FAIL single_start_lat got %0d want %0d", st - t, 1);
    end
    checks++;
    if (at != t + 12) begin
      errors++; $display("FAIL single_ack_lat got %0d want %0d", at - t, 12);
    end
    checks++;
    if (acks0 != 1 || acks1 != 0 || reads != 1) begin
      errors++; $display("FAIL single_counts got ack0=%0d ack1=%0d reads=%0d want 1 0 1", acks0, acks1, reads);
    end
    checks++;
    if (op_count !== CW'(1) || busy !== 1'b0) begin
      errors++; $display("FAIL single_opcount got %0d busy=%b want 1 busy=0", op_count, busy);
    end
  endtask

  task automatic test_both();
    int who, at;
    do_reset();
    @(negedge clk);
    a0 = 1; b0 = 2; a1 = 4; b1 = 8; req0 = 1'b1; req1 = 1'b1;
    wait_ack(40, who, at);
    if (who == 0) req0 = 1'b0;
    checks++;
    if (who != 0 || result !== W'(3)) begin
      errors++; $display("FAIL both_first got who=%0d res=%0d want who=0 res=3", who, result);
    end
    wait_ack(40, who, at);
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (who != 1 || result !== W'(12)) begin
      errors++; $display("FAIL both_second got who=%0d res=%0d want who=1 res=12", who, result);
    end
    @(negedge clk);
    checks++;
    if (op_count !== CW'(2)) begin
      errors++; $display("FAIL both_opcount got %0d want 2", op_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ea[2], eb[2];
    int turn, dbl, who, done_ops;
    logic prev_start;
    do_reset();
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin ea[r] = rnd(); eb[r] = rnd(); end
    a0 = ea[0]; b0 = eb[0]; a1 = ea[1]; b1 = eb[1];
    req0 = 1'b1; req1 = 1'b1;
    turn = 0; dbl = 0; done_ops = 0; prev_start = 1'b0;
    for (int i = 0; i < 200 && done_ops < 6; i++) begin
      @(negedge clk);
      if (mm_start && prev_start) dbl++;
      prev_start = mm_start;
      if (ack0 || ack1) begin
        who = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        checks++;
        if (who != turn || result !== (ea[turn] ^ eb[turn])) begin
          errors++; $display("FAIL b2b_op%0d got who=%0d res=%h want who=%0d res=%h",
                             done_ops, who, result, turn, ea[turn] ^ eb[turn]);
        end
        ea[turn] = rnd(); eb[turn] = rnd();
        if (turn == 0) begin a0 = ea[0]; b0 = eb[0]; end
        else begin a1 = ea[1]; b1 = eb[1]; end
        turn ^= 1;
        done_ops++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (done_ops != 6) begin
      errors++; $display("FAIL b2b_timeout got %0d ops want 6", done_ops);
    end
    checks++;
    if (dbl != 0) begin
      errors++; $display("FAIL b2b_start_width got %0d double starts want 0", dbl);
    end
    @(negedge clk);
    checks++;
    if (op_count !== CW'(6)) begin
      errors++; $display("FAIL b2b_opcount got %0d want 6", op_count);
    end
  endtask

  task automatic test_spurious();
    logic [W-1:0] ea, eb;
    int st, who, at;
    do_reset();
    @(negedge clk);
    junk = rnd() | W'(1);
    spur = 1'b1;
    #1;
    checks++;
    if (mm_out_read !== 1'b0) begin
      errors++; $display("FAIL spur_idle_read got %b want 0", mm_out_read);
    end
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (result !== '0 || ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL spur_idle_effect got res=%h ack=%b%b busy=%b want 0 00 0", result, ack0, ack1, busy);
    end
    ea = rnd(); eb = rnd();
    a0 = ea; b0 = eb; req0 = 1'b1;
    st = -1;
    for (int i = 0; i < 5 && st < 0; i++) begin
      @(negedge clk);
      if (mm_start) st = cyc;
    end
    spur = 1'b1;
    #1;
    checks++;
    if (mm_out_read !== 1'b0 || st < 0) begin
      errors++; $display("FAIL spur_issue_read got %b start=%0d want 0", mm_out_read, st);
    end
    @(negedge clk);
    spur = 1'b0;
    wait_ack(30, who, at);
    req0 = 1'b0;
    checks++;
    if (who != 0 || at != st + 11 || result !== (ea ^ eb)) begin
      errors++; $display("FAIL spur_op got who=%0d lat=%0d res=%h want 0 11 %h", who, at - st, result, ea ^ eb);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ea, eb;
    int who, at, r, st;
    do_reset();
    @(negedge clk);
    a0 = rnd(); b0 = rnd(); req0 = 1'b1;
    wait_ack(30, who, at);
    ea = rnd(); eb = rnd();
    a0 = ea; b0 = eb;
    st = -1;
    for (int i = 0; i < 5 && st < 0; i++) begin
      @(negedge clk);
      if (mm_start) st = cyc;
    end
    repeat (3) @(negedge clk);
    resetn = 1'b0; r = cyc;
    @(negedge clk);
    resetn = 1'b1;
    checks++;
    if (busy !== 1'b0 || result !== '0 || op_count !== '0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++; $display("FAIL midreset_state got busy=%b res=%h cnt=%0d ack=%b%b want 0 0 0 00",
                         busy, result, op_count, ack0, ack1);
    end
    wait_ack(30, who, at);
    req0 = 1'b0;
    checks++;
    if (who != 0 || at != r + 13 || result !== (ea ^ eb)) begin
      errors++; $display("FAIL midreset_restart got who=%0d lat=%0d res=%h want 0 13 %h", who, at - r, result, ea ^ eb);
    end
    @(negedge clk);
    checks++;
    if (op_count !== CW'(1)) begin
      errors++; $display("FAIL midreset_opcount got %0d want 1", op_count);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] ea, eb;
    int who, at, bad;
    do_reset();
    @(negedge clk);
    bad = 0;
    for (int n = 0; n < (1 << CW); n++) begin
      ea = rnd(); eb = rnd();
      a0 = ea; b0 = eb; req0 = 1'b1;
      wait_ack(30, who, at);
      if (who != 0 || result !== (ea ^ eb)) bad++;
      req0 = 1'b0;
      @(negedge clk);
      if (n == (1 << CW) - 2) begin
        checks++;
        if (op_count !== {CW{1'b1}}) begin
          errors++; $display("FAIL wrap_max got %0d want %0d", op_count, (1 << CW) - 1);
        end
      end
    end
    checks++;
    if (op_count !== '0) begin
      errors++; $display("FAIL wrap_zero got %0d want 0", op_count);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_ops got %0d bad ops want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
